// File: rtl/calendar_counter.sv
// calendar_counter -- day/month/year calendar stage driven by a day-rollover input.
//
// Advances the date once per rising edge of newDay, which may be a single-cycle pulse
// or a level. A load request writes a new date after validating it against the
// days-in-month table; a rejected load leaves the date alone and pulses loadErr.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   newDay     in   1  day-rollover indication (pulse or level)
//   load       in   1  single-cycle request to write a new date
//   loadDay    in   5  date to load, 1..31
//   loadMonth  in   4  month to load, 1..12
//   loadYear   in   7  year offset from 2000 to load, 0..127
//   day        out  5  current day, 1..31
//   month      out  4  current month, 1..12
//   year       out  7  current year offset, 0..127
//   newMonth   out  1  one-cycle pulse when the month advances
//   newYear    out  1  one-cycle pulse when the year advances
//   loadErr    out  1  one-cycle pulse when a load request is rejected
//
// Configuration:
//   CALENDAR_LEAP_YEAR_EN  when defined, February has 29 days in years with
//                          year[1:0] == 0 (2000 counts as leap); otherwise February
//                          always has 28 days.

module calendar_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       newDay,
  input  logic       load,
  input  logic [4:0] loadDay,
  input  logic [3:0] loadMonth,
  input  logic [6:0] loadYear,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       newMonth,
  output logic       newYear,
  output logic       loadErr
);

  // Days in month; returns 0 for an out-of-range month so that any load with
  // such a month fails the day-range check as well.
  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic leap);
    logic [4:0] d;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
      4'd2:                                       d = leap ? 5'd29 : 5'd28;
      default:                                    d = 5'd0;
    endcase
    return d;
  endfunction

  logic       newday_q;
  logic       advance;
  logic       cur_leap;
  logic       load_leap;
  logic [4:0] cur_dim;
  logic [4:0] load_dim;
  logic       load_ok;

`ifdef CALENDAR_LEAP_YEAR_EN
  assign cur_leap  = (year[1:0] == 2'd0);
  assign load_leap = (loadYear[1:0] == 2'd0);
`else
  assign cur_leap  = 1'b0;
  assign load_leap = 1'b0;
`endif

  // Rising edge of newDay; a level held high produces a single advance.
  assign advance = newDay & ~newday_q;

  always_comb begin
    cur_dim  = dim_of(month, cur_leap);
    load_dim = dim_of(loadMonth, load_leap);
    load_ok  = (loadDay != 5'd0) && (load_dim != 5'd0) && (loadDay <= load_dim);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // newday_q resets high so a newDay level held through reset does not advance.
      newday_q <= 1'b1;
      day      <= 5'd1;
      month    <= 4'd1;
      year     <= 7'd0;
      newMonth <= 1'b0;
      newYear  <= 1'b0;
      loadErr  <= 1'b0;
    end else begin
      newday_q <= newDay;
      newMonth <= 1'b0;
      newYear  <= 1'b0;
      loadErr  <= 1'b0;
      // Load wins over a coincident advance, which is dropped even if the load fails.
      if (load) begin
        if (load_ok) begin
          day   <= loadDay;
          month <= loadMonth;
          year  <= loadYear;
        end else begin
          loadErr <= 1'b1;
        end
      end else if (advance) begin
        if (day < cur_dim) begin
          day <= day + 5'd1;
        end else begin
          day      <= 5'd1;
          newMonth <= 1'b1;
          if (month == 4'd12) begin
            month   <= 4'd1;
            year    <= year + 7'd1;  // 127 wraps to 0
            newYear <= 1'b1;
          end else begin
            month <= month + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
- REQ-001: The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
- REQ-002: clk  in  1  system clock, rising edge only.
- REQ-003: rst  in  1  synchronous, active-high reset.
- REQ-004: newDay  in  1  day-rollover indication from the time-of-day clock stage; may be a single-cycle pulse or a level.
- REQ-005: load  in  1  single-cycle request to write a new date.
- REQ-006: loadDay  in  5  date to load, 1..31.
- REQ-007: loadMonth  in  4  month to load, 1..12.
- REQ-008: loadYear  in  7  year to load, as an offset from 2000 (0..127).
- REQ-009: day  out  5  current day, 1..31.
- REQ-010: month  out  4  current month, 1..12.
- REQ-011: year  out  7  current year offset, 0..127.
- REQ-012: newMonth  out  1  one-cycle pulse when the month advances.
- REQ-013: newYear  out  1  one-cycle pulse when the year advances.
- REQ-014: loadErr  out  1  one-cycle pulse when a load request is rejected.

Function
- REQ-015: The block SHALL register newDay every cycle and detect an advance event when newDay is 1 and the registered copy is 0 (rising edge); a newDay level held high SHALL produce exactly one advance.
- REQ-016: All outputs SHALL be registered; day, month and year SHALL reflect an advance on the clock edge after the edge that samples the newDay rising edge (1-cycle latency).
- REQ-017: Days-in-month (dim) SHALL be:
  - 31 for months 1, 3, 5, 7, 8, 10, 12;
  - 30 for months 4, 6, 9, 11;
  - 28 or 29 for month 2, per REQ-028/029.
- REQ-018: On an advance with day < dim(month, year), day SHALL increment by 1; month and year are unchanged.
- REQ-019: On an advance with day == dim:
  - day SHALL become 1;
  - month SHALL increment;
  - newMonth SHALL pulse high for 1 cycle.
- REQ-020: On an advance from day == 31 and month == 12:
  - day and month SHALL become 1;
  - year SHALL increment;
  - newMonth and newYear SHALL both pulse.
- REQ-021: Year 127 SHALL wrap to 0 on a year advance, with newYear asserted.
- REQ-022: On load, the block SHALL validate the request: 1 <= loadMonth <= 12 and 1 <= loadDay <= dim(loadMonth, loadYear).
  - If valid, it SHALL write all three fields on the next edge, with no newMonth or newYear pulse.
  - If invalid, it SHALL leave the date unchanged and pulse loadErr for 1 cycle.
- REQ-023: When load and an advance event occur in the same cycle, load SHALL take priority and the advance SHALL be discarded, whether or not the load is valid.
- REQ-024: newMonth, newYear and loadErr SHALL be 0 in every cycle not named above.

Reset
- REQ-025: When rst is sampled high, the block SHALL set:
  - day = 1, month = 1, year = 0;
  - newMonth = newYear = loadErr = 0;
  - the registered newDay copy = 1.
- REQ-026: Because the registered newDay copy resets to 1, a newDay held high through reset release SHALL NOT cause an advance.
- REQ-027: rst SHALL override load and newDay in the same cycle; a reset asserted mid-operation SHALL discard any pending event.

Configuration
- REQ-028: With macro CALENDAR_LEAP_YEAR_EN defined, dim for month 2 SHALL be 29 when year[1:0] == 0 (2000 counts as a leap year), and 28 otherwise.
- REQ-029: Without CALENDAR_LEAP_YEAR_EN, dim for month 2 SHALL always be 28, and loading day 29 in month 2 SHALL set loadErr.

Verification
- REQ-030: The bench SHALL cover the following directed scenarios:
  - Reset, then 31 newDay pulses -> day = 1, month = 2, year = 0, one newMonth pulse.
  - Load 31/12/5, then one newDay pulse -> 1/1/6, with newMonth and newYear high in the same cycle.
  - Load 28/2/4, then one newDay pulse:
    - with CALENDAR_LEAP_YEAR_EN -> 29/2/4;
    - without it -> 1/3/4.
  - Load 31/4/0 -> loadErr pulse, date unchanged; load 0/5/0 -> loadErr; load 15/13/0 -> loadErr.
  - newDay held high for 10 cycles -> exactly one advance; load 10/6/3 in the same cycle as a newDay edge -> 10/6/3, no advance.
  - Load 31/12/127, then one newDay pulse -> 1/1/0 with newYear; rst asserted with newDay high -> 1/1/0 and no advance after release.
